// File: rtl/psum_accumulator_if.sv
// psum_accumulator_if
//   Groups the configuration, input-beat and output handshake signals of
//   psum_accumulator. clk and the active-low reset stay plain module ports.
//   Signals:
//     start, cfg_len, cfg_bias   pixel start and its configuration
//     in_valid, in_ready, in_data  partial-sum beats from the adder tree
//     out_valid, out_ready, out_data  saturated result to the output writer
//     busy                       accumulator not idle
//   Modports: master (drives start/cfg/in/out_ready), slave (the accumulator).
interface psum_accumulator_if #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 48,
  parameter int MAX_LEN   = 256,
  parameter int LEN_W     = $clog2(MAX_LEN + 1)
);
  logic                 start;
  logic [LEN_W-1:0]     cfg_len;
  logic [ACC_WIDTH-1:0] cfg_bias;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 busy;

  modport master (
    output start, cfg_len, cfg_bias, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  start, cfg_len, cfg_bias, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/psum_accumulator.sv
// psum_accumulator
//   Accumulates cfg_len partial sums from the adder tree on top of a
//   programmable bias and emits one WIDTH-bit saturated result per pixel over
//   a valid/ready handshake.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-low reset
//     bus   psum_accumulator_if.slave (start/cfg, in beats, out handshake, busy)
//   Build option: define ACC_RELU_EN to clamp negative results to zero.
//
//   state | meaning
//   IDLE  | waiting for start with a non-zero length
//   ACCUM | accepting beats, one per cycle while in_valid
//   DONE  | holding the result until the consumer takes it
module psum_accumulator #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 48,
  parameter int MAX_LEN   = 256,
  parameter int LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic                clk,
  input  logic                rst,
  psum_accumulator_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t               r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [LEN_W-1:0]     r_cnt;
  logic [LEN_W-1:0]     r_len;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_out_data;
  logic                 r_busy;

  logic [ACC_WIDTH-1:0] w_sum;
  logic                 w_fits;
  logic [WIDTH-1:0]     w_sat;
  logic [WIDTH-1:0]     w_post;
  logic                 w_last;
  logic                 w_load;

  assign w_sum  = r_acc + {{(ACC_WIDTH-WIDTH){bus.in_data[WIDTH-1]}}, bus.in_data};
  // The sum fits in WIDTH bits when every bit from the WIDTH-1 sign position up is equal.
  assign w_fits = (&w_sum[ACC_WIDTH-1:WIDTH-1]) | ~(|w_sum[ACC_WIDTH-1:WIDTH-1]);
  assign w_sat  = w_fits ? w_sum[WIDTH-1:0]
                : (w_sum[ACC_WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}});
`ifdef ACC_RELU_EN
  assign w_post = w_sat[WIDTH-1] ? '0 : w_sat;
`else
  assign w_post = w_sat;
`endif

  assign w_last = (r_cnt == r_len - LEN_W'(1));
  assign w_load = bus.start && (bus.cfg_len != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_len       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_load) begin
            r_state    <= S_ACCUM;
            r_acc      <= bus.cfg_bias;
            r_cnt      <= '0;
            r_len      <= bus.cfg_len;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (bus.in_valid && r_in_ready) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + LEN_W'(1);
            if (w_last) begin
              r_state     <= S_DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_data  <= w_post;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            // A start coinciding with the handshake reloads without an IDLE bubble.
            if (w_load) begin
              r_state    <= S_ACCUM;
              r_acc      <= bus.cfg_bias;
              r_cnt      <= '0;
              r_len      <= bus.cfg_len;
              r_in_ready <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_psum_accumulator.sv
module tb_psum_accumulator;
  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  psum_accumulator_if #(.WIDTH(32), .ACC_WIDTH(48), .MAX_LEN(256)) bus ();

  psum_accumulator #(.WIDTH(32), .ACC_WIDTH(48), .MAX_LEN(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_px(input string tag, input int len, input logic [47:0] bias,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3,
                        input logic [31:0] exp);
    logic [31:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    bus.start    = 1'b1;
    bus.cfg_len  = 9'(len);
    bus.cfg_bias = bias;
    step();
    bus.start = 1'b0;
    chk({tag, "_in_ready"}, 48'(bus.in_ready), 48'd1);
    for (int i = 0; i < len; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = d[i];
      step();
    end
    bus.in_valid = 1'b0;
    chk({tag, "_out_valid"}, 48'(bus.out_valid), 48'd1);
    chk({tag, "_out_data"}, 48'(bus.out_data), 48'(exp));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_released"}, 48'(bus.out_valid), 48'd0);
    chk({tag, "_idle"}, 48'(bus.busy), 48'd0);
  endtask

  initial begin
    logic [31:0] exp_neg_sat;
    logic [31:0] exp_neg2;
    logic [31:0] pat_d [6];
    logic        pat_v [6];
    n_assert = 0;
    n_fail   = 0;
    bus.start     = 1'b0;
    bus.cfg_len   = '0;
    bus.cfg_bias  = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_in_ready", 48'(bus.in_ready), 48'd0);
    chk("rst_out_valid", 48'(bus.out_valid), 48'd0);
    chk("rst_out_data", 48'(bus.out_data), 48'd0);
    chk("rst_busy", 48'(bus.busy), 48'd0);
    step();
    step();
    rst = 1'b1;
    step();

    // 1: len 4, bias 10, beats 1..4 -> 20, one cycle after the last beat
    bus.start = 1'b1; bus.cfg_len = 9'd4; bus.cfg_bias = 48'd10;
    step();
    bus.start = 1'b0;
    chk("t1_busy", 48'(bus.busy), 48'd1);
    chk("t1_in_ready", 48'(bus.in_ready), 48'd1);
    for (int i = 1; i <= 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'(i);
      if (i == 4) chk("t1_no_early_valid", 48'(bus.out_valid), 48'd0);
      step();
    end
    bus.in_valid = 1'b0;
    chk("t1_out_valid", 48'(bus.out_valid), 48'd1);
    chk("t1_out_data", 48'(bus.out_data), 48'd20);
    chk("t1_in_ready_done", 48'(bus.in_ready), 48'd0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("t1_out_valid_clr", 48'(bus.out_valid), 48'd0);
    chk("t1_busy_clr", 48'(bus.busy), 48'd0);

    // 2: saturation
`ifdef ACC_RELU_EN
    exp_neg_sat = 32'h0000_0000;
    exp_neg2    = 32'h0000_0000;
`else
    exp_neg_sat = 32'h8000_0000;
    exp_neg2    = 32'hFFFF_FFFE;
`endif
    run_px("t2_pos_sat", 2, 48'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 0, 32'h7FFF_FFFF);
    run_px("t2_neg_sat", 2, 48'd0, 32'h8000_0000, 32'h8000_0000, 0, 0, exp_neg_sat);
    run_px("t2_neg_bias", 1, 48'hFFFF_FFFF_FFFB, 32'd3, 0, 0, 0, exp_neg2);

    // 3: gaps in in_valid are not counted
    pat_v[0] = 1; pat_v[1] = 0; pat_v[2] = 0; pat_v[3] = 1; pat_v[4] = 0; pat_v[5] = 1;
    pat_d[0] = 5; pat_d[1] = 99; pat_d[2] = 99; pat_d[3] = 6; pat_d[4] = 99; pat_d[5] = 7;
    bus.start = 1'b1; bus.cfg_len = 9'd3; bus.cfg_bias = 48'd0;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = pat_v[i];
      bus.in_data  = pat_d[i];
      if (i == 5) chk("t3_no_early_valid", 48'(bus.out_valid), 48'd0);
      step();
    end
    bus.in_valid = 1'b0;
    chk("t3_out_valid", 48'(bus.out_valid), 48'd1);
    chk("t3_out_data", 48'(bus.out_data), 48'd18);

    // 4: stall in DONE with start pulses
    for (int i = 0; i < 6; i++) begin
      bus.start    = (i % 2 == 0);
      bus.cfg_len  = 9'd2;
      bus.cfg_bias = 48'd500;
      step();
      chk("t4_hold_valid", 48'(bus.out_valid), 48'd1);
      chk("t4_hold_data", 48'(bus.out_data), 48'd18);
      chk("t4_hold_in_ready", 48'(bus.in_ready), 48'd0);
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("t4_out_valid_clr", 48'(bus.out_valid), 48'd0);
    chk("t4_idle", 48'(bus.busy), 48'd0);
    chk("t4_in_ready", 48'(bus.in_ready), 48'd0);

    // 5: zero-length start ignored; start concurrent with handshake
    bus.start = 1'b1; bus.cfg_len = 9'd0; bus.cfg_bias = 48'd77;
    step();
    bus.start = 1'b0;
    chk("t5_len0_busy", 48'(bus.busy), 48'd0);
    chk("t5_len0_in_ready", 48'(bus.in_ready), 48'd0);
    step();
    chk("t5_len0_out_valid", 48'(bus.out_valid), 48'd0);
    bus.start = 1'b1; bus.cfg_len = 9'd1; bus.cfg_bias = 48'd0;
    step();
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 32'd5;
    step();
    bus.in_valid = 1'b0;
    chk("t5_px1_data", 48'(bus.out_data), 48'd5);
    bus.out_ready = 1'b1;
    bus.start = 1'b1; bus.cfg_len = 9'd2; bus.cfg_bias = 48'd100;
    step();
    bus.out_ready = 1'b0;
    bus.start = 1'b0;
    chk("t5_b2b_out_valid", 48'(bus.out_valid), 48'd0);
    chk("t5_b2b_in_ready", 48'(bus.in_ready), 48'd1);
    chk("t5_b2b_busy", 48'(bus.busy), 48'd1);
    bus.in_valid = 1'b1; bus.in_data = 32'd1;
    step();
    chk("t5_px2_mid", 48'(bus.out_valid), 48'd0);
    bus.in_data = 32'd2;
    step();
    bus.in_valid = 1'b0;
    chk("t5_px2_valid", 48'(bus.out_valid), 48'd1);
    chk("t5_px2_data", 48'(bus.out_data), 48'd103);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // 6: reset mid-pixel discards the partial sum
    bus.start = 1'b1; bus.cfg_len = 9'd4; bus.cfg_bias = 48'd1000;
    step();
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 32'd1;
    step();
    bus.in_data = 32'd2;
    step();
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("t6_rst_busy", 48'(bus.busy), 48'd0);
    chk("t6_rst_in_ready", 48'(bus.in_ready), 48'd0);
    chk("t6_rst_out_valid", 48'(bus.out_valid), 48'd0);
    chk("t6_rst_out_data", 48'(bus.out_data), 48'd0);
    step();
    rst = 1'b1;
    step();
    chk("t6_post_rst_idle", 48'(bus.busy), 48'd0);
    run_px("t6_fresh", 1, 48'd0, 32'd7, 0, 0, 0, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
